iter_multdiv_unit: RTL and testbench

//   Multi-cycle signed 32-bit multiply/divide unit consumed by the execute stage of the 5-stage pipeline.

---
 rtl/iter_multdiv_unit.sv | 171 +++++++++++++++++
 tb/tb_iter_multdiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iter_multdiv_unit.sv
// iter_multdiv_unit
//   Multi-cycle signed multiply/divide unit for the execute stage. A start
//   pulse on ctrl_MULT or ctrl_DIV latches the operands. The unit then runs
//   one bit per cycle: shift-add for multiply, restoring division for divide.
//   data_resultRDY pulses for one cycle WIDTH cycles after the start edge.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start multiply (wins over ctrl_DIV)
//   ctrl_DIV        start divide
//   data_result     product low word or truncated quotient
//   data_exception  multiply overflow, divide-by-zero or divide overflow
//   data_resultRDY  one-cycle completion pulse
//   busy            high from the start edge through the RDY cycle
//
// state  | meaning
// IDLE   | waiting for a start request
// MUL    | shift-add iteration, one multiplier bit per cycle
// DIV    | restoring-divide iteration, one quotient bit per cycle
// DONE   | result valid, RDY pulse; a start here re-enters MUL/DIV directly

module iter_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic [WIDTH-1:0]   raw_a_q, raw_b_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               start_ok, start_mul, start_div, iterating, last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_sh;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic               mul_ovf, div_zero, div_ovf;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign start_ok  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_mul = start_ok && ctrl_MULT;
  assign start_div = start_ok && ctrl_DIV && !ctrl_MULT;
  assign iterating = (state_q == S_MUL) || (state_q == S_DIV);
  assign last_iter = iterating && (cnt_q == CNT_LAST);

  // Multiply: add into the upper half, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);

  // Divide: acc holds {rem, quot}; dividend bits enter rem from the top of mag_a.
  assign rem_sh = {acc_q[2*WIDTH-2:WIDTH], mag_a_q[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {1'b0, mag_b_q};
  assign q_bit  = !trial[WIDTH];

  always_comb begin
    acc_d = acc_q;
    if (state_q == S_MUL)
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    else if (state_q == S_DIV)
      acc_d = {(q_bit ? trial[WIDTH-1:0] : rem_sh), acc_q[WIDTH-2:0], q_bit};
  end

  assign prod_signed = neg_q ? -acc_d : acc_d;
  assign quot_signed = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
  // Product fits only if the top WIDTH+1 bits are a pure sign extension.
  assign mul_ovf  = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
  assign div_zero = (raw_b_q == '0);
  assign div_ovf  = (raw_a_q == MOST_NEG) && (raw_b_q == '1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_mul)      state_d = S_MUL;
        else if (start_div) state_d = S_DIV;
      end
      S_MUL: begin
        busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        busy           = 1'b1;
        data_resultRDY = 1'b1;
        if (start_mul)      state_d = S_MUL;
        else if (start_div) state_d = S_DIV;
        else                state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      mag_a_q        <= '0;
      mag_b_q        <= '0;
      raw_a_q        <= '0;
      raw_b_q        <= '0;
      neg_q          <= 1'b0;
      acc_q          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start_mul || start_div) begin
      mag_a_q <= magnitude(data_operandA);
      mag_b_q <= magnitude(data_operandB);
      raw_a_q <= data_operandA;
      raw_b_q <= data_operandB;
      neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      acc_q   <= '0;
      cnt_q   <= CNT_LOAD;
    end else if (iterating) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - 1'b1;
      if (state_q == S_MUL) mag_b_q <= mag_b_q >> 1;
      else                  mag_a_q <= mag_a_q << 1;
      if (last_iter) begin
        if (state_q == S_MUL) begin
          data_result    <= prod_signed[WIDTH-1:0];
          data_exception <= mul_ovf;
        end else if (div_zero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end else if (div_ovf) begin
          data_result    <= MOST_NEG;
          data_exception <= 1'b1;
        end else begin
          data_result    <= quot_signed;
          data_exception <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_multdiv_unit.sv
module tb_iter_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV  = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  iter_multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   rdy_seen = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  // Monitor: every RDY pulse pops one expected response.
  always @(negedge clock) begin
    if (reset && data_resultRDY) begin
      rdy_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_res"}, data_result, e.res);
        check({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
        check({e.name, "_lat"}, cyc, e.cyc);
      end
    end
  end

  // Drive a start at a negedge; the start edge is the following posedge,
  // so RDY is expected at the negedge 33 cycle-counts later.
  task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] res, input bit exc,
                          input string nm);
    exp_t e;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
    if (push) begin
      e.res = res; e.exc = exc; e.cyc = cyc + 33; e.name = nm;
      sb_q.push_back(e);
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit exc, input string nm);
    start_op(is_div, a, b, 1'b1, res, exc, nm);
    wait_rdy(nm);
    @(negedge clock);
    check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   saved;

    #3;
    check("rst_result", data_result, 32'd0);
    check("rst_exc",    {31'd0, data_exception}, 32'd0);
    check("rst_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // T1
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3");
    // T2
    run_op(1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "mul_ovf_2p32");
    run_op(1'b0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, "mul_max_1");
    run_op(1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, "mul_min_1");
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "mul_min_m1");
    // T3
    run_op(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_m7_2");
    run_op(1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, "div_100_m7");
    run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0, "div_m100_m7");
    run_op(1'b1, 32'd0,        32'd5,        32'd0,        1'b0, "div_0_5");
    // T4
    run_op(1'b1, 32'd5,        32'd0,        32'd0,        1'b1, "div_by_zero");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_min_m1");
    run_op(1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0, "div_min_1");
    // T5: DIV request during MUL is ignored
    start_op(1'b0, 32'd6, 32'hFFFFFFFB, 1'b1, 32'hFFFFFFE2, 1'b0, "mul_ignore_div");
    repeat (4) @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    check("busy_during_mul", {31'd0, busy}, 32'd1);
    wait_rdy("mul_ignore_div");
    @(negedge clock);
    check("ignore_busy_after", {31'd0, busy}, 32'd0);

    // T5: start in the RDY cycle
    start_op(1'b0, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, "b2b_first");
    wait_rdy("b2b_first");
    data_operandA = 32'd9;
    data_operandB = 32'hFFFFFFF7;
    ctrl_MULT     = 1'b1;
    e.res = 32'hFFFFFFAF; e.exc = 1'b0; e.cyc = cyc + 33; e.name = "b2b_second";
    sb_q.push_back(e);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check("b2b_busy_held", {31'd0, busy}, 32'd1);
    check("b2b_rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    wait_rdy("b2b_second");
    @(negedge clock);
    check("b2b_busy_after", {31'd0, busy}, 32'd0);

    // T6: asynchronous reset mid-divide
    start_op(1'b1, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, "div_abort");
    saved = rdy_seen;
    repeat (8) @(negedge clock);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_result", data_result, 32'd0);
    check("abort_exc",    {31'd0, data_exception}, 32'd0);
    check("abort_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("abort_busy",   {31'd0, busy}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_no_rdy", rdy_seen, saved);
    run_op(1'b0, 32'd6, 32'd7, 32'd42, 1'b0, "mul_6_7_after_rst");

    repeat (2) @(negedge clock);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
